// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, PC step, reset PC default,
// and the {instr, pc} bundle handed from fetch to decode.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INCR = 32'd4;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response channel plus decode handoff.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
    import mips_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [WORD_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [WORD_W-1:0] imem_rsp_data;
    logic              id_valid;
    logic              id_ready;
    logic [WORD_W-1:0] id_instr;
    logic [WORD_W-1:0] id_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push/pop/flush and occupancy output.
// Ports: clk, reset (async high), flush, push, wdata, pop, rdata (head), occ.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    occ
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + AW'(1);
    endfunction

    assign do_push = push & (occ_q != FULL_CNT);
    assign do_pop  = pop & (occ_q != '0);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = bump(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = bump(rd_ptr_q);
            end
            occ_d = occ_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign occ   = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: issues imem word reads for pc_in, queues
// in-order responses, hands {instr, pc} to decode, and computes next_pc.
// Ports: clk, reset (async high), pc_in, next_pc, redirect, redirect_target,
// bus (fetch_unit_if.master: imem req/rsp channel and decode channel).
module fetch_unit
    import mips_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc_in,
    output logic [WORD_W-1:0] next_pc,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_target,
    fetch_unit_if.master      bus
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(QUEUE_DEPTH);

    logic              req_fire, pop, rsp_live, iq_push;
    logic [CW-1:0]     in_flight_q, in_flight_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     iq_occ, tag_occ;
    logic [CW:0]       used;
    logic [WORD_W-1:0] tag_pc;
    fetch_pkt_t        iq_wdata, iq_rdata;

    // A pop in the redirect cycle is discarded along with the queue.
    assign pop = bus.id_valid & bus.id_ready & ~redirect;

    // Credit: outstanding (stale included) plus queued must stay below depth,
    // which keeps the instruction queue from ever overflowing.
    assign used = {1'b0, in_flight_q} + {1'b0, iq_occ} - {{CW{1'b0}}, pop};

    assign bus.imem_req_valid = ~reset & ~redirect & (used < CREDITS);
    assign bus.imem_req_addr  = {pc_in[WORD_W-1:2], 2'b00};

    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_live = bus.imem_rsp_valid & (drop_cnt_q == '0);
    assign iq_push  = rsp_live & ~redirect;

    always_comb begin
        next_pc = pc_in;
        if (redirect) begin
            next_pc = redirect_target;
        end else if (req_fire) begin
            next_pc = pc_in + PC_INCR;
        end
    end

    always_comb begin
        in_flight_d = in_flight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        drop_cnt_d  = drop_cnt_q;
        if (redirect) begin
            // Everything still outstanding after this cycle is stale.
            drop_cnt_d = in_flight_q - CW'(bus.imem_rsp_valid);
        end else if (bus.imem_rsp_valid && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // PC of each live outstanding request, matched to responses in order.
    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (WORD_W)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (req_fire),
        .wdata (bus.imem_req_addr),
        .pop   (iq_push),
        .rdata (tag_pc),
        .occ   (tag_occ)
    );

    assign iq_wdata = '{instr: bus.imem_rsp_data, pc: tag_pc};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_pkt_t))
    ) u_instr_q (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (iq_push & (tag_occ != '0)),
        .wdata (iq_wdata),
        .pop   (pop),
        .rdata (iq_rdata),
        .occ   (iq_occ)
    );

    assign bus.id_valid = (iq_occ != '0);
    assign bus.id_instr = bus.id_valid ? iq_rdata.instr : '0;
    assign bus.id_pc    = bus.id_valid ? iq_rdata.pc : RESET_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with in-bench PC register,
// in-order imem model and decode-side monitor.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_target;

    fetch_unit_if bus ();

    fetch_unit #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_q),
        .next_pc         (next_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RST_PC;
        else pc_q <= next_pc;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    lat_max = 1;
    logic  prev_redir = 1'b0;
    logic [31:0] hold_addr = '0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_id_valid"}, {31'b0, bus.id_valid}, 32'd0);
        check({tag, "_id_instr"}, bus.id_instr, 32'd0);
        check({tag, "_id_pc"}, bus.id_pc, RST_PC);
        check({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'd0);
    endtask

    // Decode-side monitor: pops expected pairs whenever decode consumes one.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_redir = 1'b0;
        end else begin
            if (prev_redir)
                check("flush_id_valid", {31'b0, bus.id_valid}, 32'd0);
            if (bus.id_valid && bus.id_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_pop cyc=%0d: got pc %h expected none",
                             cyc, bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", bus.id_pc, e.pc);
                    check("id_instr", bus.id_instr, e.instr);
                end
            end
            prev_redir = redirect;
        end
    end

    task automatic drive(input int n);
        int r;
        reset = (n == 1500 || n == 1501);
        if (reset) begin
            mem_q.delete();
            exp_q.delete();
        end
        redirect = 1'b0;
        redirect_target = $urandom() & 32'hFFFF_FFFC;
        if (n < 20) begin
            lat_max = 1;
            bus.imem_req_ready = 1'b1;
            bus.id_ready = 1'b1;
        end else if (n < 40) begin
            lat_max = 1;
            bus.imem_req_ready = !(n >= 30 && n <= 32);
            bus.id_ready = !(n >= 20 && n <= 24);
        end else begin
            lat_max = 3;
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.id_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (n == 40 || r < 2) begin
                redirect = 1'b1;
                redirect_target = 32'hFFFF_FFF4;
            end else if (r < 4) begin
                redirect = 1'b1;
                redirect_target = 32'h0000_0100;
            end else if (r < 7) begin
                redirect = 1'b1;
            end
        end
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = $urandom();
        if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            if (n < 40 || $urandom_range(0, 4) != 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data = imem(mem_q[0].addr);
            end
        end
    endtask

    task automatic record(input int n);
        logic [31:0] exp_np;
        logic        fire;
        if (reset) begin
            check_reset_state("midrst");
            return;
        end
        fire = bus.imem_req_valid & bus.imem_req_ready;
        exp_np = redirect ? redirect_target : fire ? pc_q + 32'd4 : pc_q;
        if (pc_q == 32'hFFFF_FFFC && fire && !redirect)
            check("wrap_next_pc", next_pc, 32'h0);
        else
            check("next_pc", next_pc, exp_np);
        if (bus.imem_req_valid)
            check("req_addr", bus.imem_req_addr, pc_q & 32'hFFFF_FFFC);
        if (redirect)
            check("redir_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        if (exp_q.size() > DEPTH) begin
            tests++;
            fails++;
            $display("FAIL credit_overflow cyc=%0d: got %0d expected <= %0d",
                     cyc, exp_q.size(), DEPTH);
        end
        if (n >= 2 && n < 20) begin
            check("stream_valid", {31'b0, bus.id_valid}, 32'd1);
            check("stream_pc", bus.id_pc, 32'(4 * (n - 2)));
        end
        if (n == 24)
            check("stall_credit", {31'b0, bus.imem_req_valid}, 32'd0);
        if (n == 30) hold_addr = bus.imem_req_addr;
        if (n == 31 || n == 32) begin
            check("hold_valid", {31'b0, bus.imem_req_valid}, 32'd1);
            check("hold_addr", bus.imem_req_addr, hold_addr);
        end
        if (bus.imem_rsp_valid) void'(mem_q.pop_front());
        if (redirect) exp_q.delete();
        if (fire) begin
            mem_q.push_back('{addr: pc_q & 32'hFFFF_FFFC,
                              due: cyc + $urandom_range(1, lat_max)});
            exp_q.push_back('{instr: imem(pc_q & 32'hFFFF_FFFC),
                              pc: pc_q & 32'hFFFF_FFFC});
        end
        if (mem_q.size() > DEPTH) begin
            tests++;
            fails++;
            $display("FAIL inflight_overflow cyc=%0d: got %0d expected <= %0d",
                     cyc, mem_q.size(), DEPTH);
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.id_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        cyc = 0;
        for (int n = 0; n < NCYC; n++) begin
            drive(n);
            @(negedge clk);
            record(n);
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
